axis_byte_packer: RTL and testbench
===================================

Name: axis_byte_packer

Overview:
- Upstream neighbour of the AXI-Stream network processor.
- Receives an 8-bit AXI-Stream byte stream, typically from the host UART/byte link, and assembles it into WORD_WIDTH-bit words, most significant byte first.
- Presents each word on a registered AXI-Stream master that drives the processor's s_axis input directly.
- A partial word that stalls for too long is discarded, so the framing resynchronises after line glitches.

Parameters:
- WORD_WIDTH, default 16: output word width in bits (>=1); equals the processor's input width.
- TIMEOUT_CYCLES, default 1000000: consecutive idle cycles after which a partial word is discarded; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  8  input byte.
- s_axis_tvalid  in  1  input byte valid.
- s_axis_tready  out  1  input byte accepted when high together with tvalid.
- m_axis_tdata  out  WORD_WIDTH  assembled word.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  downstream ready.
- timeout_err  out  1  one-cycle pulse when a partial word is discarded.

Behaviour:
- NB = ceil(WORD_WIDTH/8) bytes per word. The internal assembly register is asm[NB*8-1:0]; the byte index is idx, 0..NB-1.
- Byte accept (acc) = s_axis_tvalid && s_axis_tready.
  - For idx < NB-1, the byte is written to asm[(NB-1-idx)*8 +: 8], and idx increments.
  - The first byte lands in the most significant position.
- Final byte (idx == NB-1 with acc):
  - The word is {asm upper bytes, new byte}[NB*8-1 -: WORD_WIDTH], i.e. the top WORD_WIDTH bits.
  - Padding in the LSBs of the last byte is discarded.
  - The word loads m_axis_tdata, m_axis_tvalid <= 1, idx <= 0, and asm is cleared.
- Latency: m_axis_tvalid rises on the clock edge that accepts the final byte, i.e. the word is visible in the following cycle.
- s_axis_tready = !rst && (idx != NB-1 || !m_axis_tvalid || m_axis_tready).
  - This is the only combinational path, m_axis_tready to s_axis_tready, and it is permitted.
  - Result: sustained throughput is one byte per cycle, including NB=1.
- Output register:
  - m_axis_tvalid clears on m_axis_tvalid && m_axis_tready, unless a new final byte is accepted on the same edge; in that case the new word loads and tvalid stays 1.
  - m_axis_tdata holds stable while m_axis_tvalid && !m_axis_tready.
  - m_axis_tdata retains its last value after handshake; it is not cleared.
- Non-final bytes keep being accepted while an output word is stalled. Only the final byte of the next word waits.
- Timeout counter tcnt, width ceil(log2(TIMEOUT_CYCLES+1)):
  - Reset to 0 on acc or whenever idx == 0.
  - Otherwise it increments each cycle.
  - When idx != 0, no acc, and tcnt == TIMEOUT_CYCLES-1: on that edge idx <= 0, asm <= 0, tcnt <= 0, and timeout_err is high for exactly the next cycle.
  - Result: a partial word survives exactly TIMEOUT_CYCLES-1 idle cycles, and is discarded at the end of the TIMEOUT_CYCLES-th.
  - A byte accepted in the cycle the timeout would fire takes priority: no flush, and the byte is stored normally.
- The timeout never affects a pending output word.
- When TIMEOUT_CYCLES == 0, tcnt logic is absent and timeout_err is tied to 0.
- Reset (rst high at an edge) sets m_axis_tvalid = 0, m_axis_tdata = 0, idx = 0, asm = 0, tcnt = 0, timeout_err = 0. s_axis_tready is 0 while rst is high.
- Reset mid-word or with a stalled output discards both; no partial word is ever emitted.
- s_axis_tdata is ignored unless acc. There is no tlast; framing is purely positional, by byte count.

Test Plan (WORD_WIDTH=12, NB=2, TIMEOUT_CYCLES=4 unless stated):
- Bytes 0xAB, 0xCD on consecutive cycles, m_axis_tready=1 -> m_axis_tdata=0xABC, m_axis_tvalid high 1 cycle after the 0xCD accept; then 0xDE, 0xF0 -> 0xDEF with no bubble.
- m_axis_tready=0, send 0x12,0x34,0x56,0x78:
  - 0x123 is held stable; 0x56 is accepted; s_axis_tready=0 at the 0x78 byte.
  - Raise tready -> 0x123 handshakes, 0x78 is accepted the same cycle, 0x567 appears next cycle.
- Send 0x11, idle 4 cycles -> timeout_err pulses once, no output. Then 0x22,0x33 -> 0x223.
- Send 0x11, idle 3 cycles, then 0x99 in the 4th -> no timeout_err, output 0x119.
- Assert rst with one byte buffered and a stalled output word:
  - m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0 during rst.
  - Next bytes 0xAA,0xBB -> 0xAAB.
- WORD_WIDTH=8, TIMEOUT_CYCLES=0, continuous bytes 0..255 with tready=1 -> one word per cycle, identical sequence, timeout_err never high.

Source files
------------

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream byte stream into WORD_WIDTH-bit words, MSB first,
// and drops a stalled partial word after TIMEOUT_CYCLES idle cycles.
module axis_byte_packer #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [WORD_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  timeout_err
);

  localparam int unsigned NB = (WORD_WIDTH + 7) / 8;
  localparam int unsigned AW = NB * 8;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  logic [IW-1:0]         idx_q, idx_d;
  logic [AW-1:0]         asm_q, asm_d, full;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  acc, last, flush;

  assign last          = (idx_q == IW'(NB - 1));
  // The final byte may only enter when the output slot is free or draining now.
  assign s_axis_tready = !rst && (!last || !valid_q || m_axis_tready);
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;

  always_comb begin
    // Low byte of asm_q is never written, so OR-ing in the new byte completes the word.
    full    = asm_q | AW'(s_axis_tdata);
    idx_d   = idx_q;
    asm_d   = asm_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && m_axis_tready) valid_d = 1'b0;
    if (acc) begin
      if (last) begin
        data_d  = WORD_WIDTH'(full >> (AW - WORD_WIDTH));
        valid_d = 1'b1;
        idx_d   = '0;
        asm_d   = '0;
      end else begin
        for (int unsigned b = 0; b + 1 < NB; b++) begin
          if (idx_q == IW'(b)) asm_d[(NB-1-b)*8 +: 8] = s_axis_tdata;
        end
        idx_d = idx_q + IW'(1);
      end
    end else if (flush) begin
      idx_d = '0;
      asm_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q;

    // An accepted byte wins over an expiring count.
    assign flush = (idx_q != '0) && !acc && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
      tcnt_d = tcnt_q + TW'(1);
      if (acc || idx_q == '0 || flush) tcnt_d = '0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        tcnt_q <= '0;
        err_q  <= 1'b0;
      end else begin
        tcnt_q <= tcnt_d;
        err_q  <= flush;
      end
    end

    assign timeout_err = err_q;
  end else begin : g_no_timeout
    assign flush       = 1'b0;
    assign timeout_err = 1'b0;
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed bench for axis_byte_packer: a 12-bit/timeout-4 instance and an
// 8-bit/no-timeout instance, with expected words queued as stimulus is driven.
module tb_axis_byte_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [11:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        terr;

  logic [7:0]  s8_tdata = '0;
  logic        s8_tvalid = 1'b0;
  logic        s8_tready;
  logic [7:0]  m8_tdata;
  logic        m8_tvalid;
  logic        m8_tready = 1'b1;
  logic        terr8;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] q12[$];
  logic [7:0]  q8[$];

  always #5 clk = ~clk;

  axis_byte_packer #(.WORD_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .timeout_err   (terr)
  );

  axis_byte_packer #(.WORD_WIDTH(8), .TIMEOUT_CYCLES(0)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s8_tdata),
    .s_axis_tvalid (s8_tvalid),
    .s_axis_tready (s8_tready),
    .m_axis_tdata  (m8_tdata),
    .m_axis_tvalid (m8_tvalid),
    .m_axis_tready (m8_tready),
    .timeout_err   (terr8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte and return 1 ns after the edge that accepts it.
  task automatic put_byte(input logic [7:0] b);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = b;
    #1;
    while (!s_tready && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    assert (s_tready) else begin
      errors++;
      $error("FAIL accept_%0h: observed tready %0b expected 1 within 20 cycles", b, s_tready);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  // Pop the next expected word and compare it with the visible output.
  task automatic expect_word(input string tag);
    logic [11:0] e;
    checks++;
    assert (q12.size() > 0) else begin
      errors++;
      $error("FAIL %s: observed word %0h expected no word queued", tag, m_tdata);
    end
    if (q12.size() > 0) begin
      e = q12.pop_front();
      check(tag, 32'({m_tvalid, m_tdata}), 32'({1'b1, e}));
    end
  endtask

  initial begin
    logic       err8_seen;
    logic [7:0] e8;
    err8_seen = 1'b0;

    // Reset
    tick();
    tick();
    check("rst_valid", 32'(m_tvalid), 0);
    check("rst_data", 32'(m_tdata), 0);
    check("rst_sready", 32'(s_tready), 0);
    check("rst_terr", 32'(terr), 0);
    check("rst_valid8", 32'(m8_tvalid), 0);
    rst = 1'b0;
    #1;
    check("post_rst_sready", 32'(s_tready), 1);

    // Back-to-back words, downstream always ready
    m_tready = 1'b1;
    put_byte(8'hAB);
    check("abc_not_yet", 32'(m_tvalid), 0);
    q12.push_back(12'hABC);
    put_byte(8'hCD);
    expect_word("word_abc");
    q12.push_back(12'hDEF);
    put_byte(8'hDE);
    check("abc_drained", 32'(m_tvalid), 0);
    put_byte(8'hF0);
    expect_word("word_def");
    tick();
    check("def_drained", 32'(m_tvalid), 0);

    // Stalled output: non-final bytes flow, final byte waits
    m_tready = 1'b0;
    q12.push_back(12'h123);
    put_byte(8'h12);
    put_byte(8'h34);
    check("stall_123_data", 32'({m_tvalid, m_tdata}), 32'h1123);
    put_byte(8'h56);
    check("stall_sready_lo", 32'(s_tready), 0);
    s_tvalid = 1'b1;
    s_tdata  = 8'h78;
    tick();
    check("stall_hold1", 32'({m_tvalid, m_tdata}), 32'h1123);
    check("stall_sready_lo2", 32'(s_tready), 0);
    tick();
    check("stall_hold2", 32'({m_tvalid, m_tdata}), 32'h1123);
    m_tready = 1'b1;
    #1;
    check("release_sready", 32'(s_tready), 1);
    expect_word("word_123");
    q12.push_back(12'h567);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    expect_word("word_567");
    tick();
    check("567_drained", 32'(m_tvalid), 0);

    // Timeout discards a lone byte after 4 idle cycles
    put_byte(8'h11);
    tick();
    tick();
    tick();
    check("to_not_yet", 32'(terr), 0);
    tick();
    check("to_pulse", 32'(terr), 1);
    check("to_no_word", 32'(m_tvalid), 0);
    tick();
    check("to_pulse_end", 32'(terr), 0);
    q12.push_back(12'h223);
    put_byte(8'h22);
    put_byte(8'h33);
    expect_word("word_223");
    tick();

    // Byte arriving in the expiring cycle wins
    put_byte(8'h11);
    tick();
    tick();
    tick();
    q12.push_back(12'h119);
    put_byte(8'h99);
    check("late_no_terr", 32'(terr), 0);
    expect_word("word_119");
    tick();
    check("late_no_terr2", 32'(terr), 0);

    // Reset with a stalled word and a buffered byte
    m_tready = 1'b0;
    put_byte(8'h5A);
    put_byte(8'h5B);
    check("pre_rst_stall", 32'({m_tvalid, m_tdata}), 32'h15A5);
    put_byte(8'hC3);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(m_tvalid), 0);
    check("mid_rst_data", 32'(m_tdata), 0);
    check("mid_rst_sready", 32'(s_tready), 0);
    tick();
    rst = 1'b0;
    m_tready = 1'b1;
    q12.push_back(12'hAAB);
    put_byte(8'hAA);
    put_byte(8'hBB);
    expect_word("word_aab");
    tick();
    check("q12_empty", 32'(q12.size()), 0);

    // 8-bit instance: one word per cycle
    for (int i = 0; i < 256; i++) begin
      s8_tvalid = 1'b1;
      s8_tdata  = 8'(i);
      q8.push_back(8'(i));
      #1;
      check("w8_sready", 32'(s8_tready), 1);
      @(posedge clk);
      #1;
      if (terr8) err8_seen = 1'b1;
      e8 = q8.pop_front();
      check("w8_word", 32'({m8_tvalid, m8_tdata}), 32'({1'b1, e8}));
    end
    s8_tvalid = 1'b0;
    tick();
    if (terr8) err8_seen = 1'b1;
    check("w8_drained", 32'(m8_tvalid), 0);
    check("w8_no_terr", 32'(err8_seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
